// File: rtl/bios_loader.sv
// Boot-time sequencer: streams the boot ROM image into memory at BASE and holds the CPU
// in reset until every word has been accepted by the memory write port.
module bios_loader #(
    parameter int unsigned    DW   = 8,
    parameter int unsigned    AW   = 14,
    parameter int unsigned    MAW  = 20,
    parameter logic [MAW-1:0] BASE = 20'hFC000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    output logic           rom_ce,
    input  logic [DW-1:0]  rom_data,
    input  logic [AW-1:0]  rom_addr,
    output logic [MAW-1:0] mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic           mem_wr,
    input  logic           mem_ack,
    output logic           busy,
    output logic           done,
    output logic           cpu_reset
);

    typedef enum logic [2:0] {StIdle, StPrime, StLatch, StWrite, StDone} state_e;

    localparam logic [AW:0]   NumWords = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   LastWord = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0]   CntOne   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] AddrOne  = {{(AW-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [AW:0]    cnt_q, cnt_d, cnt_inc;
    logic [MAW-1:0] addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           wr_q, wr_d;
    logic           done_q, done_d;
    logic           cpu_reset_q, cpu_reset_d;
    logic [AW-1:0]  rom_off;

    // The ROM has already advanced past the word it presents, so its offset is one behind.
    assign rom_off = rom_addr - AddrOne;
    assign cnt_inc = cnt_q + CntOne;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        done_d      = done_q;
        cpu_reset_d = cpu_reset_q;
        rom_ce      = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = StPrime;
                end
            end
            StPrime: begin
                busy    = 1'b1;
                rom_ce  = 1'b1;
                state_d = StLatch;
            end
            StLatch: begin
                busy    = 1'b1;
                rom_ce  = (cnt_q != LastWord);
                wdata_d = rom_data;
                addr_d  = BASE + {{(MAW-AW){1'b0}}, rom_off};
                wr_d    = 1'b1;
                state_d = StWrite;
            end
            StWrite: begin
                busy = 1'b1;
                if (mem_ack) begin
                    wr_d  = 1'b0;
                    cnt_d = cnt_inc;
                    if (cnt_inc == NumWords) begin
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                        state_d     = StDone;
                    end else begin
                        state_d = StLatch;
                    end
                end
            end
            StDone: begin
                if (start) begin
                    done_d      = 1'b0;
                    cpu_reset_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StPrime;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            done_q      <= done_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr    = wr_q;
    assign done      = done_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_bios_loader.sv
// Bench for bios_loader: streaming ROM model, ack generator and a per-word load model
// compared against the DUT outputs every cycle.
module tb_bios_loader;

    localparam int NW   = 16;
    localparam int Base = 'h100;

    logic        clock = 1'b0;
    logic        reset, start, mem_ack, rom_adv;
    logic        rom_ce, mem_wr, busy, done, cpu_reset;
    logic [3:0]  rom_ptr  = 4'd0;
    logic [7:0]  rom_data = 8'd0;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;
    bit chk_en = 1'b0;

    // Load model: a load is a priming cycle, then per word one latch cycle and a write
    // phase that ends on the first sampled ack.
    bit   m_load = 1'b0, m_done = 1'b0, m_wr = 1'b0;
    int   m_pre = 0, m_words = 0, m_off0 = 0, m_pulses = 0;
    int   wcount[NW];
    logic [7:0]  img[NW];
    logic [19:0] f_addr, l_addr;
    logic [7:0]  f_data, l_data;

    bios_loader #(
        .DW  (8),
        .AW  (4),
        .MAW (20),
        .BASE(20'h00100)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rom_ce   (rom_ce),
        .rom_data (rom_data),
        .rom_addr (rom_ptr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wr   (mem_wr),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .done     (done),
        .cpu_reset(cpu_reset)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [7:0] rom_word(input int i);
        logic [7:0] v;
        v = 8'(i) ^ 8'hA5;
        return v;
    endfunction

    // Auto-incrementing ROM; rom_adv lets the bench move its address without the DUT.
    always @(posedge clock) begin
        if (rom_ce || rom_adv) begin
            rom_data <= rom_word(int'(rom_ptr));
            rom_ptr  <= rom_ptr + 4'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int age;
        age = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            age = (mem_wr === 1'b1) ? age + 1 : 0;
            case (ack_mode)
                0:       mem_ack = 1'b1;
                1:       mem_ack = (mem_wr === 1'b1) && (age > 3);
                default: mem_ack = (mem_wr === 1'b1) ? ($urandom_range(0, 2) == 0)
                                                      : ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    task automatic model_step();
        int idx;
        if (rom_ce === 1'b1) m_pulses++;
        if (reset) begin
            m_load = 1'b0;
            m_done = 1'b0;
            m_wr   = 1'b0;
            m_pre  = 0;
        end else if (m_load) begin
            if (m_wr) begin
                if (mem_ack) begin
                    idx = int'(mem_addr) - Base;
                    if (idx < 0 || idx >= NW) begin
                        chk("write_in_range", 32'(mem_addr), 32'(Base));
                    end else begin
                        wcount[idx]++;
                        img[idx] = mem_wdata;
                    end
                    if (m_words == 0) begin
                        f_addr = mem_addr;
                        f_data = mem_wdata;
                    end
                    l_addr = mem_addr;
                    l_data = mem_wdata;
                    m_wr = 1'b0;
                    m_words++;
                    if (m_words == NW) begin
                        m_load = 1'b0;
                        m_done = 1'b1;
                        chk("rom_ce_pulses", 32'(m_pulses), 32'(NW));
                        chk("rom_addr_restored", 32'(rom_ptr), 32'(m_off0));
                    end else begin
                        m_pre = 1;
                    end
                end
            end else begin
                m_pre--;
                if (m_pre == 0) m_wr = 1'b1;
            end
        end else if (start) begin
            m_load   = 1'b1;
            m_done   = 1'b0;
            m_words  = 0;
            m_pre    = 2;
            m_off0   = int'(rom_ptr);
            m_pulses = 0;
            for (int i = 0; i < NW; i++) wcount[i] = 0;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    always @(negedge clock) begin
        int off;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_load));
            chk("done", 32'(done), 32'(m_done));
            chk("cpu_reset", 32'(cpu_reset), 32'(!m_done));
            chk("mem_wr", 32'(mem_wr), 32'(m_wr));
            if (m_wr) begin
                off = (m_off0 + m_words) % NW;
                chk("mem_addr", 32'(mem_addr), 32'(Base + off));
                chk("mem_wdata", 32'(mem_wdata), 32'(rom_word(off)));
            end
        end
    end

    task automatic advance_rom(input int n);
        if (n > 0) begin
            rom_adv = 1'b1;
            repeat (n) @(posedge clock);
            #1;
            rom_adv = 1'b0;
        end
    endtask

    task automatic run_load(input bit rand_start, output int cyc, output int bcyc);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("start_done_low", 32'(done), 32'd0);
        chk("start_cpu_reset_high", 32'(cpu_reset), 32'd1);
        cyc  = 0;
        bcyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            if (busy === 1'b1) bcyc++;
            if (rand_start) start = ($urandom_range(0, 3) == 0);
            @(posedge clock);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk("load_completes", 32'(done), 32'd1);
    endtask

    task automatic check_image();
        for (int i = 0; i < NW; i++) begin
            chk("image_write_count", 32'(wcount[i]), 32'd1);
            chk("image_data", 32'(img[i]), 32'(rom_word(i)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bcyc, n;
        reset   = 1'b1;
        start   = 1'b0;
        rom_adv = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_rom_ce", 32'(rom_ce), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (2) @(posedge clock);
        #1;

        // Full load with ack tied high, including while idle.
        ack_mode = 0;
        run_load(1'b0, cyc, bcyc);
        chk("t1_done_cycle", 32'(cyc), 32'd33);
        chk("t1_busy_cycles", 32'(bcyc), 32'd33);
        chk("t1_first_addr", 32'(f_addr), 32'h100);
        chk("t1_first_data", 32'(f_data), 32'hA5);
        chk("t1_last_addr", 32'(l_addr), 32'h10F);
        chk("t1_last_data", 32'(l_data), 32'hAA);
        check_image();

        // Non-zero ROM start offset, started from DONE.
        advance_rom(5);
        run_load(1'b0, cyc, bcyc);
        chk("t2_first_addr", 32'(f_addr), 32'h105);
        chk("t2_first_data", 32'(f_data), 32'hA0);
        chk("t2_last_addr", 32'(l_addr), 32'h104);
        chk("t2_last_data", 32'(l_data), 32'hA1);
        chk("t2_rom_addr_end", 32'(rom_ptr), 32'd5);
        check_image();

        // Three ack wait states per write: five cycles per word.
        ack_mode = 1;
        repeat (2) @(posedge clock);
        #1;
        run_load(1'b0, cyc, bcyc);
        chk("t3_done_cycle", 32'(cyc), 32'd81);
        chk("t3_busy_cycles", 32'(bcyc), 32'd81);
        check_image();

        // Reset in the 7th write, then a clean reload.
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0;
        while (!(m_words == 6 && m_wr) && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("t4_reached_7th_write", 32'(m_words == 6 && m_wr), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("t4_mem_wr", 32'(mem_wr), 32'd0);
        chk("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_rom_ce", 32'(rom_ce), 32'd0);
        chk("t4_mem_addr", 32'(mem_addr), 32'd0);
        chk("t4_mem_wdata", 32'(mem_wdata), 32'd0);
        ack_mode = 0;
        @(posedge clock);
        #1;
        run_load(1'b0, cyc, bcyc);
        check_image();

        // Random acks, stray acks while idle, start pulses while busy.
        ack_mode = 2;
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(posedge clock);
            #1;
            advance_rom(int'($urandom_range(0, 7)));
            run_load(1'b1, cyc, bcyc);
            check_image();
        end
        repeat (3) @(posedge clock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bios_loader.md
# bios_loader

Boot-time sequencer that copies the full contents of the streaming boot ROM (the auto-incrementing `rom` instance) into the system memory write port at a fixed base address. It holds the CPU in reset until the image is resident. It sits between the boot ROM, the memory arbiter's write port and the CPU reset input. It drives the ROM's `ce` and derives each destination address from the ROM's `out_address`, so it does not depend on the ROM address counter's power-up value.

## Interface
- `DW`, 8: ROM and memory data width.
- `AW`, 14: ROM address width; image size is 2^AW words.
- `MAW`, 20: memory address width.
- `BASE`, 20'hFC000: destination address of ROM word 0 (16 KB image ends at 20'hFFFFF).

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  load request, sampled in IDLE and DONE.
- `rom_ce`  out  1  to ROM `ce`.
- `rom_data`  in  DW  from ROM `data_out`.
- `rom_addr`  in  AW  from ROM `out_address`.
- `mem_addr`  out  MAW  write address.
- `mem_wdata`  out  DW  write data.
- `mem_wr`  out  1  write request.
- `mem_ack`  in  1  write accepted.
- `busy`  out  1  load in progress.
- `done`  out  1  image resident (sticky).
- `cpu_reset`  out  1  CPU reset hold; high until load completes.

## Operation
- **ROM behaviour relied on:** a `rom_ce` high cycle makes `rom_data` equal to the word at the old address and `rom_addr` equal to old+1, both valid the next cycle. The word in `rom_data` therefore has offset `rom_addr - 1`, computed mod 2^AW.
- **IDLE:** all outputs idle. `start` goes to PRIME.
- **PRIME:** `rom_ce` = 1 for one cycle, then go to LATCH.
- **LATCH** (one cycle):
  - Register `mem_wdata` <= `rom_data`.
  - Register `mem_addr` <= `BASE` + zero-extended (`rom_addr` - 1).
  - `rom_ce` = 1 unless this is the last word.
  - Set `mem_wr` at the transition to WRITE.
- **WRITE:** `mem_wr` held high with `mem_addr`/`mem_wdata` stable until `mem_ack` is sampled high.
  - On ack, clear `mem_wr` and increment the word counter.
  - Counter reaching 2^AW: go to DONE. Otherwise go to LATCH.
- **DONE:** `done` = 1, `cpu_reset` = 0, `busy` = 0. `start` clears `done`, raises `cpu_reset` and goes to PRIME (reload).
- **Word counter:** AW+1 bits, cleared on leaving IDLE/DONE.
- **ROM pulse count:** exactly 2^AW `rom_ce` pulses per load (1 in PRIME + 2^AW−1 in LATCH). The ROM address ends where it started, and every offset 0..2^AW−1 is written exactly once, whatever the starting address.
- `busy` = 1 in PRIME, LATCH and WRITE.
- `start` is ignored while busy.
- `mem_ack` is ignored outside WRITE.
- `rom_ce` and `busy` are state-decoded. `mem_wr`, `mem_addr`, `mem_wdata`, `done` and `cpu_reset` are registered.

## Timing
- **Reset values:** `rom_ce` 0, `mem_wr` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `cpu_reset` 1; state IDLE.
- **Mid-load reset:** the outstanding write is abandoned and `mem_wr` is low the cycle after `reset` is sampled. The ROM address is not reset; a later load is still complete because addressing is relative.
- **Load start:** `start` sampled at edge 0 puts the block in PRIME in cycle 1.
- **Cycles per word:** 1 (LATCH) + 1 + W, where W = ack wait cycles (W = 0 when `mem_ack` is already high in the first WRITE cycle).
- **Load completion, W = 0:** word k is in WRITE at cycle 3+2k. `done` rises and `cpu_reset` falls at the edge ending cycle 2^(AW+1)+1.
- **Address wrap:** `mem_addr` arithmetic is MAW wide. `BASE` + offset must not exceed 2^MAW−1; this is not checked.
- **Simultaneous events:**
  - `start` together with `reset`: reset wins.
  - `mem_ack` in the last WRITE together with `start`: go to DONE; `start` is honoured only from DONE in a later cycle.

## Test plan
1. **Full load, no wait states.** AW=4, BASE=20'h00100, ROM d[i]=i^8'hA5, ROM address 0, `mem_ack` tied high, pulse `start`.
   - 16 writes to 0x100..0x10F with data d[i].
   - `rom_ce` pulses = 16.
   - `done` rises and `cpu_reset` falls at edge ending cycle 33; `busy` high cycles 1–33.
2. **Non-zero ROM start.** Pre-advance the ROM 5 pulses, then load.
   - First write 0x105/d[5]; last write 0x104/d[4].
   - Every address 0x100–0x10F written exactly once with correct data.
   - ROM address back at 5 afterwards.
3. **Ack delayed 3 cycles per write.**
   - `mem_addr`/`mem_wdata` stable while `mem_wr` is high.
   - 5 cycles per word; still 16 writes and 16 `rom_ce` pulses.
4. **Mid-load reset.** Assert `reset` during the 7th WRITE.
   - Next cycle: all outputs at reset values (`cpu_reset` 1, `mem_wr` 0).
   - A new `start` produces a complete, correct 16-word image.
5. **Protocol robustness.**
   - `start` pulses while busy: no effect.
   - `mem_ack` high in IDLE: no effect.
   - `start` in DONE: `done` clears, `cpu_reset` rises next cycle, and a full reload follows.
